bit_scan_encoder: RTL
=====================

# bit_scan_encoder

Sequential successor to the combinational encoder: accepts an `INPUT_WIDTH`-bit request vector through a valid/ready handshake and emits the index of every set bit, one index per cycle, lowest index first, with a `last` flag on the final beat. It serves wherever a multi-hot vector must be serialised into binary indices, such as interrupt-pending scans, free-slot enumeration or bitmap walks. Like the combinational encoder, it supports non-power-of-two widths without over-generating.

## Interface
- `INPUT_WIDTH`, default 8: request vector width, ≥1.
- `IDX_WIDTH` (localparam): `$clog2(max(INPUT_WIDTH, 2))`.
- `clk_i`  input  1: clock.
- `rst_ni`  input  1: reset, asynchronous, active-low.
- `select_i`  input  INPUT_WIDTH: request vector, sampled only on input handshake.
- `valid_i`  input  1: `select_i` valid.
- `ready_o`  output  1: block can accept a vector.
- `index_o`  output  IDX_WIDTH: binary index of the current set bit.
- `valid_o`  output  1: `index_o` valid.
- `last_o`  output  1: current beat is the final one for this vector.
- `ready_i`  input  1: downstream accepts the beat.
- `empty_o`  output  1: present only with `BIT_SCAN_EMPTY_EN`; beat carries no index.

## Operation
- Registers: `pending` (INPUT_WIDTH bits) and a state in {IDLE, SCAN, EMPTY}. EMPTY exists only with the macro.
- Input handshake: `valid_i && ready_o`. Output handshake: `valid_o && ready_i`.
- IDLE:
  - `ready_o`=1, `valid_o`=0.
  - On input handshake with nonzero `select_i`: `pending` ← `select_i`, go to SCAN.
  - On a zero vector: see Configuration.
- SCAN:
  - `valid_o`=1.
  - `index_o` = lowest set bit of `pending`.
  - `last_o` = `pending` has exactly one bit set.
  - On output handshake: clear that bit in `pending`.
    - If `last_o`, go to IDLE.
    - Otherwise stay in SCAN.
- Back-to-back: in SCAN, `ready_o` = `last_o && ready_i`. A vector may be accepted on the same edge as the final beat's handshake and then loads `pending` directly, skipping IDLE. This is a combinational `ready_i`→`ready_o` path and is permitted.
- Stability: while `valid_o && !ready_i`, the outputs `index_o`, `last_o` and `empty_o` hold constant. `select_i` changes outside a handshake have no effect.
- Reset (asserting `rst_ni` at any time, including mid-scan) immediately forces:
  - state IDLE, `pending`=0;
  - `valid_o`=0, `last_o`=0, `index_o`=0, `empty_o`=0, `ready_o`=1.
  - In-flight beats are discarded.
- Outside SCAN/EMPTY, `index_o` and `last_o` are 0.
- `INPUT_WIDTH`=1: `index_o` is 1 bit and is always 0.

## Timing
- Latency: vector accepted at edge N → first beat valid in the cycle after N.
- Throughput: one index per cycle while `ready_i`=1. A vector with k set bits occupies exactly k output beats.
- Sustained back-to-back vectors produce no bubble cycles.
- All state is updated on the rising edge of `clk_i`. Reset is asynchronous on assertion; the first acceptance is possible on the first edge after deassertion.
- `index_o`, `last_o` and `valid_o` are combinational from registers only. Only `ready_o` depends combinationally on an input.

## Configuration
- Macro `BIT_SCAN_EMPTY_EN`.
- Defined:
  - `empty_o` port exists.
  - A zero vector is accepted and goes to EMPTY, which emits one beat: `valid_o`=1, `empty_o`=1, `last_o`=1, `index_o`=0.
  - On the output handshake in EMPTY, return to IDLE, or accept the next vector under the back-to-back rule.
  - `empty_o`=0 on all SCAN beats.
- Undefined:
  - No `empty_o` port and no EMPTY state.
  - A zero vector is accepted (handshake completes) and silently dropped; the block stays in IDLE with no output beat.

## Test plan
- `INPUT_WIDTH`=8, `select_i`=8'b1010_0100, `ready_i`=1 → `index_o`=2, 5, 7 on three consecutive cycles after acceptance; `last_o` only with 7; then `valid_o`=0.
- Same vector, `ready_i` low for 3 cycles on the first beat → `index_o`=2 and `valid_o`=1 held for all 3 cycles; 5 and 7 follow once `ready_i`=1.
- Vector 8'h06 followed by 8'h01 presented during beat index 2 with `ready_i`=1 → `ready_o`=1 on that cycle; next cycle `index_o`=0 with `last_o`=1; no idle gap.
- Zero vector:
  - Macro defined: one beat with `empty_o`=1, `last_o`=1, `index_o`=0.
  - Macro undefined: `ready_o` stays 1 and `valid_o` never rises.
- Reset mid-scan: 8'hFF, assert `rst_ni`=0 during beat index 3 → `valid_o`=0 immediately, `ready_o`=1; after release, no further beats until a new vector is accepted.
- Non-power-of-two and minimum width:
  - `INPUT_WIDTH`=5, `select_i`=5'b10001 → `index_o`=0 then 4 with `last_o`; `index_o` is 3 bits.
  - `INPUT_WIDTH`=1, `select_i`=1 → single beat, `index_o`=0, `last_o`=1.

Source files
------------

// File: rtl/bit_scan_encoder.sv
// bit_scan_encoder
// Serialises a multi-hot request vector into the binary indices of its set
// bits, one index per output beat, lowest index first, with last_o marking
// the final beat of each vector.
//
// Optional feature macro: BIT_SCAN_EMPTY_EN
//   defined   : a zero vector produces one beat flagged by empty_o
//   undefined : a zero vector is accepted and silently dropped
//
// Handshake semantics (both sides): a transfer happens on a rising clk_i
// edge where valid and ready are both high. The producer holds its payload
// stable while valid is high and ready is low. ready_o may depend
// combinationally on ready_i (back-to-back acceptance on the final beat);
// valid_o, index_o, last_o and empty_o depend on registers only.

module bit_scan_encoder #(
  parameter int INPUT_WIDTH = 8,
  localparam int IDX_WIDTH = $clog2((INPUT_WIDTH > 2) ? INPUT_WIDTH : 2)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [INPUT_WIDTH-1:0] select_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [IDX_WIDTH-1:0]   index_o,
  output logic                   valid_o,
  output logic                   last_o,
  input  logic                   ready_i
`ifdef BIT_SCAN_EMPTY_EN
  ,
  output logic                   empty_o
`endif
);

  // Scan states. EMPTY only exists when zero vectors produce a beat.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1
`ifdef BIT_SCAN_EMPTY_EN
    ,
    ST_EMPTY = 2'd2
`endif
  } state_e;

  state_e                 state_q, state_d;
  logic [INPUT_WIDTH-1:0] pending_q, pending_d;

  // Derived views of the pending vector.
  logic [INPUT_WIDTH-1:0] pending_minus_one;
  logic [INPUT_WIDTH-1:0] pending_cleared;
  logic                   pending_single;
  logic [IDX_WIDTH-1:0]   low_idx;

  logic in_hs;
  logic out_hs;
  logic select_nonzero;

`ifndef BIT_SCAN_EMPTY_EN
  logic empty_int;
`endif

  // Clearing the lowest set bit: x & (x - 1). The same product tells us
  // whether exactly one bit is set (nonzero and nothing left after clearing).
  always_comb begin
    pending_minus_one = pending_q - INPUT_WIDTH'(1);
    pending_cleared   = pending_q & pending_minus_one;
    pending_single    = (pending_q != '0) && (pending_cleared == '0);
    select_nonzero    = (select_i != '0);
  end

  // Lowest set bit index: scan downwards so the last hit is the lowest.
  always_comb begin
    low_idx = '0;
    for (int i = INPUT_WIDTH - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        low_idx = IDX_WIDTH'(i);
      end
    end
  end

  // Output decode: everything except ready_o comes from registers only.
  always_comb begin
    ready_o = 1'b1;
    valid_o = 1'b0;
    last_o  = 1'b0;
    index_o = '0;
`ifdef BIT_SCAN_EMPTY_EN
    empty_o = 1'b0;
`else
    empty_int = 1'b0;
`endif
    case (state_q)
      ST_SCAN: begin
        valid_o = 1'b1;
        index_o = low_idx;
        last_o  = pending_single;
        // A new vector may be taken only as the final beat leaves.
        ready_o = pending_single && ready_i;
      end
`ifdef BIT_SCAN_EMPTY_EN
      ST_EMPTY: begin
        valid_o = 1'b1;
        last_o  = 1'b1;
        empty_o = 1'b1;
        ready_o = ready_i;
      end
`endif
      default: begin
        ready_o = 1'b1;
      end
    endcase
  end

  assign in_hs  = valid_i && ready_o;
  assign out_hs = valid_o && ready_i;

  // Next-state: retire the current beat first, then let an accepted vector
  // overwrite pending (an accept outside IDLE only happens on the last beat).
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;

    if (out_hs) begin
      pending_d = pending_cleared;
      if (last_o) begin
        state_d   = ST_IDLE;
        pending_d = '0;
      end
    end

    if (in_hs) begin
      if (select_nonzero) begin
        pending_d = select_i;
        state_d   = ST_SCAN;
      end else begin
`ifdef BIT_SCAN_EMPTY_EN
        pending_d = '0;
        state_d   = ST_EMPTY;
`else
        // Zero vector is consumed with no output beat.
        pending_d = '0;
        state_d   = ST_IDLE;
`endif
      end
    end
  end

  // State and pending registers; reset discards any in-flight vector.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

endmodule
